// File: rtl/dual_view_read_sched.sv
// Dual-view read scheduler: issues SDRAM read strobes for the left/right windows,
// re-aligns returned RGB565 data and expands it to 10-bit components. Define
// DUAL_VIEW_SWAP_EN to allow a per-frame left/right port swap via SWAP.
module dual_view_read_sched #(
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 240,
  parameter int RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME_START,
  input  logic        VGA_DE,
  input  logic [10:0] X_ADDR,
  input  logic [10:0] Y_ADDR,
  input  logic        SWAP,
  input  logic [15:0] Read_DATA1,
  input  logic [15:0] Read_DATA2,
  output logic        Read1,
  output logic        Read2,
  output logic        RD_LOAD,
  output logic [9:0]  VGA_iRed,
  output logic [9:0]  VGA_iGreen,
  output logic [9:0]  VGA_iBlue,
  output logic        DE_OUT,
  output logic        CNT_ERR,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [10:0] X_SPLIT     = 11'(WIN_W);
  localparam logic [10:0] X_END       = 11'(2 * WIN_W);
  localparam logic [10:0] Y_END       = 11'(WIN_H);
  localparam logic [19:0] FRAME_READS = 20'(WIN_W * WIN_H);

  state_t      state;
  logic [18:0] cnt1;
  logic [18:0] cnt2;
  logic        swap_flag;
  logic [19:0] total1;
  logic [19:0] total2;

  logic                  hit1;
  logic                  hit2;
  logic                  issue;
  logic                  rd1_n;
  logic                  rd2_n;
  logic [1:0]            win_a;
  logic                  de_a;
  logic [RD_LAT:0][1:0]  psel_p;
  logic [RD_LAT:0]       de_p;

  assign fsm_state = state;

  // Read strobes are one-cycle requests with no back-pressure: a strobe high in
  // cycle c means port data for that pixel is valid RD_LAT cycles later.
  assign hit1  = VGA_DE && (X_ADDR < X_SPLIT) && (Y_ADDR < Y_END);
  assign hit2  = VGA_DE && (X_ADDR >= X_SPLIT) && (X_ADDR < X_END) && (Y_ADDR < Y_END);
  assign issue = (state == ACTIVE) && !FRAME_START;
  assign rd1_n = issue && (swap_flag ? win_a[1] : win_a[0]);
  assign rd2_n = issue && (swap_flag ? win_a[0] : win_a[1]);

  // Include a strobe counted on the same edge that samples FRAME_START.
  assign total1 = {1'b0, cnt1} + {19'd0, Read1};
  assign total2 = {1'b0, cnt2} + {19'd0, Read2};

  function automatic logic [29:0] expand565(input logic [15:0] d);
    return {d[4:0], 5'd0, d[10:5], 4'd0, d[15:11], 5'd0};
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      RD_LOAD   <= 1'b0;
      cnt1      <= '0;
      cnt2      <= '0;
      CNT_ERR   <= 1'b0;
      swap_flag <= 1'b0;
    end else begin
      RD_LOAD <= 1'b0;
      if (Read1 && (cnt1 != '1)) cnt1 <= cnt1 + 19'd1;
      if (Read2 && (cnt2 != '1)) cnt2 <= cnt2 + 19'd1;
      case (state)
        IDLE: begin
          if (FRAME_START) begin
            state   <= LOAD;
            RD_LOAD <= 1'b1;
          end
        end
        LOAD: begin
          state <= ACTIVE;
          cnt1  <= '0;
          cnt2  <= '0;
`ifdef DUAL_VIEW_SWAP_EN
          swap_flag <= SWAP;
`else
          swap_flag <= SWAP & 1'b0;
`endif
        end
        ACTIVE: begin
          if (FRAME_START) begin
            if ((total1 != FRAME_READS) || (total2 != FRAME_READS)) CNT_ERR <= 1'b1;
            state   <= LOAD;
            RD_LOAD <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port select and DE ride alongside the strobes so the colour mux picks the
  // port whose data is valid in the cycle it registers the pixel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_a      <= '0;
      de_a       <= 1'b0;
      Read1      <= 1'b0;
      Read2      <= 1'b0;
      psel_p     <= '0;
      de_p       <= '0;
      DE_OUT     <= 1'b0;
      VGA_iRed   <= '0;
      VGA_iGreen <= '0;
      VGA_iBlue  <= '0;
    end else begin
      win_a  <= {hit2, hit1};
      de_a   <= VGA_DE;
      Read1  <= rd1_n;
      Read2  <= rd2_n;
      psel_p <= {psel_p[RD_LAT-1:0], rd2_n, rd1_n};
      de_p   <= {de_p[RD_LAT-1:0], de_a};
      DE_OUT <= de_p[RD_LAT];
      case (psel_p[RD_LAT])
        2'b01:   {VGA_iRed, VGA_iGreen, VGA_iBlue} <= expand565(Read_DATA1);
        2'b10:   {VGA_iRed, VGA_iGreen, VGA_iBlue} <= expand565(Read_DATA2);
        default: {VGA_iRed, VGA_iGreen, VGA_iBlue} <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_view_read_sched.sv
// Bench for dual_view_read_sched on a reduced 16x8 window geometry: table vectors,
// full/short frames, fixed-colour edge pixels, swap behaviour and mid-frame reset.
module tb_dual_view_read_sched;
  localparam int WIN_W       = 16;
  localparam int WIN_H       = 8;
  localparam int RD_LAT      = 1;
  localparam int LINE_W      = 2 * WIN_W + 4;
  localparam int LINES       = WIN_H + 4;
  localparam int FRAME_READS = WIN_W * WIN_H;
`ifdef DUAL_VIEW_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, vga_de, swap;
  logic [10:0] x_addr, y_addr;
  logic [15:0] read_data1, read_data2;
  logic        read1, read2, rd_load, de_out, cnt_err;
  logic [9:0]  red, green, blue;
  logic [1:0]  fsm_state;

  dual_view_read_sched #(.WIN_W(WIN_W), .WIN_H(WIN_H), .RD_LAT(RD_LAT)) dut (
    .CLK(clk), .RST(rst), .FRAME_START(frame_start), .VGA_DE(vga_de),
    .X_ADDR(x_addr), .Y_ADDR(y_addr), .SWAP(swap),
    .Read_DATA1(read_data1), .Read_DATA2(read_data2),
    .Read1(read1), .Read2(read2), .RD_LOAD(rd_load),
    .VGA_iRed(red), .VGA_iGreen(green), .VGA_iBlue(blue),
    .DE_OUT(de_out), .CNT_ERR(cnt_err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];
  logic [1:0]  rd_q[$];

  typedef struct {
    bit de;
    int x;
    int y;
    int port;
  } vec_t;
  vec_t vecs[12];

  logic        use_fixed;
  logic [15:0] fix1, fix2;
  int          rsp_n1, rsp_n2;
  int          m1, m2, mcnt1, mcnt2;
  bit          m_active, m_swap, m_load_next, prev_fs, exp_err;
  int          rd1_total, rd2_total;
  bit          both_seen;

  function automatic logic [15:0] data_fn(input int port, input int n);
    logic [15:0] v;
    v = 16'(n * 1237 + 15450);
    if (port == 2) v = v ^ 16'hA5F0;
    return v;
  endfunction

  function automatic logic [29:0] exp_rgb(input logic [15:0] d);
    logic [4:0] b5, r5;
    logic [5:0] g6;
    b5 = d[15:11];
    g6 = d[10:5];
    r5 = d[4:0];
    return {r5, 5'd0, g6, 4'd0, b5, 5'd0};
  endfunction

  // SDRAM port model with one cycle of read latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_n1 <= 0;
      rsp_n2 <= 0;
      read_data1 <= '0;
      read_data2 <= '0;
    end else begin
      if (read1) begin
        read_data1 <= use_fixed ? fix1 : data_fn(1, rsp_n1);
        rsp_n1 <= rsp_n1 + 1;
      end
      if (read2) begin
        read_data2 <= use_fixed ? fix2 : data_fn(2, rsp_n2);
        rsp_n2 <= rsp_n2 + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_strobes"}, {30'd0, read2, read1}, 32'd0);
    check({tag, "_rd_load"}, {31'd0, rd_load}, 32'd0);
    check({tag, "_rgb"}, {2'd0, red, green, blue}, 32'd0);
    check({tag, "_de_out"}, {31'd0, de_out}, 32'd0);
    check({tag, "_cnt_err"}, {31'd0, cnt_err}, 32'd0);
    check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0; vga_de = 1'b0; x_addr = '0; y_addr = '0; swap = 1'b0;
    exp_q.delete();
    rd_q.delete();
    m1 = 0; m2 = 0; mcnt1 = 0; mcnt2 = 0;
    m_active = 0; m_swap = 0; m_load_next = 0; prev_fs = 0; exp_err = 0;
    repeat (3) @(negedge clk);
    zero_checks("reset");
    rst = 1'b0;
  endtask

  // One pixel clock: score the outputs visible now, then drive the next pixel.
  task automatic step(input bit fs, input bit de, input int x, input int y, input int fport = -1);
    logic [30:0] e;
    logic [1:0]  er;
    logic [15:0] d;
    int          port;
    @(negedge clk);
    if (read1 && read2) both_seen = 1'b1;
    if (read1) rd1_total++;
    if (read2) rd2_total++;
    check("rd_load", {31'd0, rd_load}, {31'd0, prev_fs});
    check("state", {30'd0, fsm_state}, prev_fs ? 32'd1 : (m_active ? 32'd2 : 32'd0));
    if (rd_q.size() == 2) begin
      er = rd_q.pop_front();
      check("strobe", {30'd0, read2, read1}, {30'd0, er});
    end
    if (exp_q.size() == RD_LAT + 3) begin
      e = exp_q.pop_front();
      check("pixel", {1'b0, de_out, red, green, blue}, {1'b0, e});
    end
    frame_start = fs; vga_de = de; x_addr = 11'(x); y_addr = 11'(y);
    if (m_load_next) begin
      m_swap = SWAP_EN && swap;
      m_load_next = 1'b0;
    end
    port = 0;
    if (fs) begin
      if (m_active && (mcnt1 != FRAME_READS || mcnt2 != FRAME_READS)) exp_err = 1'b1;
      mcnt1 = 0; mcnt2 = 0;
      m_active = 1'b1;
      m_load_next = 1'b1;
    end else if (fport >= 0) begin
      port = fport;
    end else if (m_active && de && y < WIN_H) begin
      if (x < WIN_W) port = m_swap ? 2 : 1;
      else if (x < 2 * WIN_W) port = m_swap ? 1 : 2;
    end
    e = {de, 30'd0};
    if (port == 1) begin
      d = use_fixed ? fix1 : data_fn(1, m1);
      m1++; mcnt1++;
      e[29:0] = exp_rgb(d);
    end else if (port == 2) begin
      d = use_fixed ? fix2 : data_fn(2, m2);
      m2++; mcnt2++;
      e[29:0] = exp_rgb(d);
    end
    rd_q.push_back({port == 2, port == 1});
    exp_q.push_back(e);
    prev_fs = fs;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, LINES);
  endtask

  task automatic run_frame();
    for (int y = 0; y < LINES; y++)
      for (int x = 0; x < LINE_W; x++)
        step(1'b0, x < 2 * WIN_W, x, y);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 0, 0, 1};
    vecs[1]  = '{1'b1, WIN_W - 1, 0, 1};
    vecs[2]  = '{1'b1, WIN_W, 0, 2};
    vecs[3]  = '{1'b1, 2 * WIN_W - 1, 0, 2};
    vecs[4]  = '{1'b1, 2 * WIN_W, 0, 0};
    vecs[5]  = '{1'b1, 5, WIN_H - 1, 1};
    vecs[6]  = '{1'b1, 5, WIN_H, 0};
    vecs[7]  = '{1'b1, 20, WIN_H - 1, 2};
    vecs[8]  = '{1'b0, 3, 3, 0};
    vecs[9]  = '{1'b1, 100, WIN_H, 0};
    vecs[10] = '{1'b1, 2047, 2047, 0};
    vecs[11] = '{1'b1, 2 * WIN_W - 1, WIN_H - 1, 2};
    use_fixed = 1'b0; fix1 = '0; fix2 = '0;
    both_seen = 1'b0; rd1_total = 0; rd2_total = 0;

    do_reset();

    // idle: active pixels before any frame start produce nothing
    for (int x = 0; x < 2 * WIN_W; x++) step(1'b0, 1'b1, x, 0);
    blank(1);

    // frame 1: full frame
    step(1'b1, 1'b0, 0, LINES);
    rd1_total = 0; rd2_total = 0;
    run_frame();
    blank(2);
    check("frame_reads1", 32'(rd1_total), 32'(FRAME_READS));
    check("frame_reads2", 32'(rd2_total), 32'(FRAME_READS));

    // frame 2: table vectors, then fixed colours on the window boundary
    step(1'b1, 1'b0, 0, LINES);
    blank(2);
    check("cnt_err_good", {31'd0, cnt_err}, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b0, vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].port);
    blank(3);
    use_fixed = 1'b1; fix1 = 16'hF800; fix2 = 16'h001F;
    step(1'b0, 1'b1, WIN_W - 1, 0);
    step(1'b0, 1'b1, WIN_W, 0);
    blank(3);
    check("rgb_left_edge", {2'd0, red, green, blue}, {2'd0, 10'd0, 10'd0, 10'd992});
    blank(1);
    check("rgb_right_edge", {2'd0, red, green, blue}, {2'd0, 10'd992, 10'd0, 10'd0});
    blank(2);
    use_fixed = 1'b0;

    // short frame 2 must raise the sticky error
    step(1'b1, 1'b0, 0, LINES);
    blank(2);
    check("cnt_err_short", {31'd0, cnt_err}, 32'd1);
    run_frame();
    blank(2);

    // frame 4 requests a swap at load; mid-frame toggle is ignored
    swap = 1'b1;
    step(1'b1, 1'b0, 0, LINES);
    blank(2);
    check("cnt_err_sticky", {31'd0, cnt_err}, 32'd1);
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b1, WIN_W, 0);
    swap = 1'b0;
    step(1'b0, 1'b1, 0, 1);
    step(1'b0, 1'b1, WIN_W, 1);
    blank(2);

    // mid-line reset while Read1 is high
    step(1'b1, 1'b0, 0, LINES);
    blank(1);
    for (int x = 0; x < 6; x++) step(1'b0, 1'b1, x, 2);
    check("pre_rst_read1", {31'd0, read1}, 32'd1);
    #2 rst = 1'b1;
    #1 zero_checks("async");
    do_reset();
    rd1_total = 0; rd2_total = 0;
    for (int x = 0; x < 2 * WIN_W; x++) step(1'b0, 1'b1, x, 1);
    blank(2);
    check("post_rst_no_reads", 32'(rd1_total + rd2_total), 32'd0);

    // reads resume after the next frame start
    step(1'b1, 1'b0, 0, LINES);
    for (int x = 0; x < 2 * WIN_W; x++) step(1'b0, 1'b1, x, 0);
    blank(RD_LAT + 4);
    check("both_strobes", {31'd0, both_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
